// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe: two-stage sign-magnitude add/subtract unit with
// valid/ready handshakes on both sides and C/Z/V/N condition codes.
module sm_addsub_pipe #(
    parameter int N    = 24,
    parameter int TAGW = 4
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            InValid,
    output logic            InReady,
    input  logic [N-1:0]    FracA,
    input  logic            SignA,
    input  logic [N-1:0]    FracB,
    input  logic            SignB,
    input  logic            Op,
    input  logic [TAGW-1:0] TagIn,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [N-1:0]    Result,
    output logic            ResultHi,
    output logic            SignR,
    output logic [TAGW-1:0] TagOut,
    output logic            ccc,
    output logic            ccz,
    output logic            ccv,
    output logic            ccn
);
    localparam int W = N + 2;

    typedef struct packed {
        logic [W-1:0]    add_a;
        logic [W-1:0]    add_b;
        logic [TAGW-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [N-1:0]    res;
        logic            hi;
        logic            sgn;
        logic [TAGW-1:0] tag;
        logic            c;
        logic            z;
    } s2_t;

    logic            s1_valid_q, s1_valid_d;
    logic            s2_valid_q, s2_valid_d;
    s1_t             s1_q, s1_d;
    s2_t             s2_q, s2_d;
    logic            s2_adv;
    logic            s1_adv;
    logic            sign_be;
    logic [W-1:0]    ext_a;
    logic [W-1:0]    ext_b;
    logic [W:0]      sum;
    logic [N:0]      neg_s;
    logic [N:0]      mag;

    assign s2_adv  = !s2_valid_q || OutReady;
    assign s1_adv  = s2_adv;
    assign InReady = !s1_valid_q || s1_adv;

    always_comb begin
        sign_be    = SignB ^ Op;
        ext_a      = SignA ? -{2'b00, FracA} : {2'b00, FracA};
        ext_b      = sign_be ? -{2'b00, FracB} : {2'b00, FracB};
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (InReady) begin
            s1_valid_d = InValid;
            if (InValid) begin
                s1_d.add_a = ext_a;
                s1_d.add_b = ext_b;
                s1_d.tag   = TagIn;
            end
        end
    end

    // |sum| < 2^(N+1), so negating only the low N+1 bits is exact
    always_comb begin
        sum        = {1'b0, s1_q.add_a} + {1'b0, s1_q.add_b};
        neg_s      = -sum[N:0];
        mag        = sum[W-1] ? neg_s : sum[N:0];
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.res = mag[N-1:0];
                s2_d.hi  = mag[N];
                s2_d.sgn = sum[W-1];
                s2_d.tag = s1_q.tag;
                s2_d.c   = sum[W];
                s2_d.z   = (mag == '0);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign OutValid = s2_valid_q;
    assign Result   = s2_q.res;
    assign ResultHi = s2_q.hi;
    assign SignR    = s2_q.sgn;
    assign TagOut   = s2_q.tag;
    assign ccc      = s2_q.c;
    assign ccz      = s2_q.z;
    assign ccv      = s2_q.hi;
    assign ccn      = s2_q.sgn;
endmodule

// File: doc/sm_addsub_pipe.md
Name: sm_addsub_pipe

Overview:
Parametrised, two-stage pipelined sign-magnitude add/subtract unit for the fixed-point datapath.
- Accepts two N-bit magnitudes with sign bits and an operation select (add or subtract).
- Returns a sign-magnitude result with an explicit carry-out magnitude bit and condition codes (C, Z, V, N).
- Sits between the operand-alignment stage and the normaliser.
- Uses valid/ready handshakes on both sides, so the pipeline can stall without losing data.

Parameters:
N, 24, magnitude width of operands and result.
TAGW, 4, width of the sideband tag carried alongside each operation (must be >= 1).

Ports:
Clock  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
InValid  input  1  operand set present
InReady  output  1  unit can accept operands this cycle
FracA  input  N  magnitude of operand A
SignA  input  1  sign of A (1 = negative)
FracB  input  N  magnitude of operand B
SignB  input  1  sign of B
Op  input  1  0 = A+B, 1 = A-B
TagIn  input  TAGW  sideband tag, passed through unchanged
OutValid  output  1  result present
OutReady  input  1  downstream accepts result
Result  output  N  magnitude of result, low N bits
ResultHi  output  1  magnitude bit N (magnitude >= 2^N)
SignR  output  1  sign of result
TagOut  output  TAGW  tag of this result
ccc  output  1  carry out of the (N+2)-bit two's-complement addition
ccz  output  1  result magnitude is zero
ccv  output  1  magnitude overflowed N bits (equals ResultHi)
ccn  output  1  result negative (equals SignR)

Behaviour:
- Reset: async assert on Reset_n low. Both stage valid bits clear, and all output registers clear. OutValid, Result, ResultHi, SignR, TagOut and all flags read 0; InReady = 1 once the pipeline is empty.
- Reset mid-operation discards all in-flight operations. No output follows release.
- Handshake:
  - A transfer occurs when Valid && Ready on the same cycle edge.
  - Stage 2 advances when it is empty or OutReady = 1.
  - Stage 1 advances when stage 2 can advance or stage 2 is empty.
  - InReady = !S1Valid || stage-1-advances. It is combinational from OutReady; no combinational path exists from InValid.
  - Outputs are held stable while OutValid && !OutReady.
- Latency and throughput: 2 cycles from accepted input to OutValid with no stall; throughput 1 op/cycle.
- Stage 1 (registered):
  - Effective B sign: SignBe = SignB ^ Op.
  - Extend each operand to N+2 bits as two's complement: a negative sign gives the negation of {2'b00, Frac}, otherwise {2'b00, Frac}.
  - The register captures both addends and the tag.
- Stage 2 (registered):
  - Compute the (N+3)-bit sum {ccc, S} = AddA + AddB.
  - S[N+1] is the sign.
  - Magnitude M = S[N+1] ? -S : S, giving N+1 bits. Result = M[N-1:0] and ResultHi = M[N].
  - SignR = S[N+1], ccn = SignR, ccz = (M == 0), ccv = ResultHi.
- The magnitude cannot exceed 2^(N+1)-2, so the N+2-bit sum never wraps.
- Zero results are always positive: +0, SignR = 0. This includes -0 + -0 and x - x.
- A negative zero input (Sign = 1, Frac = 0) is treated as 0.
- Simultaneous input accept and output consume on the same edge is legal; full throughput is kept.
- No other state exists; the tag is purely sideband.

Test Plan (N=8, TAGW=4):
- Reset release, then A=+5, B=-3, Op=0, Tag=1 → after 2 cycles OutValid=1, Result=2, SignR=0, ResultHi=0, ccz=0, ccn=0, TagOut=1.
- A=+5, B=+9, Op=1 → Result=4, SignR=1, ccn=1; then A=+3, B=-4, Op=1 → Result=7, SignR=0.
- A=-255, B=-255, Op=0 → Result=0xFE, ResultHi=1, ccv=1, SignR=1; then A=+255, B=+1 → Result=0x00, ResultHi=1, ccz=0.
- A=+7, B=+7, Op=1 → Result=0, SignR=0, ccz=1; A=-0, B=-0, Op=0 → Result=0, SignR=0, ccz=1.
- Stream 6 back-to-back ops with tags 0..5, OutReady low for 4 cycles mid-stream:
  - InReady deasserts once both stages are full.
  - No op is lost or duplicated; TagOut order is 0..5; outputs stay stable while stalled.
- Two ops in flight, pulse Reset_n low for 1 cycle asynchronously → OutValid=0 immediately, no stale results after release, InReady=1.
